// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_cfg_pkg
// Brief    : Shared types for the FPGA configuration-chain controller.
// Revision : 1.0 - initial release
// ============================================================================
package fpga_cfg_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        LOAD    = 2'd0,
        VERIFY  = 2'd1,
        CLEAR   = 2'd2,
        ILLEGAL = 2'd3
    } cfg_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_serializer
// Brief    : LSB-first PISO shift register with a count of valid bits left.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_serializer
    import fpga_cfg_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int BC_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [BC_W-1:0]   load_bits,
    input  logic              shift,
    output logic              ser_bit,
    output logic              empty
);

    logic [DATA_W-1:0] r_sreg;
    logic [BC_W-1:0]   r_bitcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg   <= '0;
            r_bitcnt <= '0;
        end else if (load) begin
            r_sreg   <= load_data;
            r_bitcnt <= load_bits;
        end else if (shift) begin
            r_sreg <= r_sreg >> 1;
            if (r_bitcnt != '0) begin
                r_bitcnt <= r_bitcnt - BC_W'(1);
            end
        end
    end

    assign ser_bit = r_sreg[0];
    // High while the final loaded bit sits on ser_bit: the next shift drains the word.
    assign empty   = (r_bitcnt <= BC_W'(1));

endmodule
`default_nettype wire

// File: rtl/fpga_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpga_cfg_ctrl
// Brief    : Command/stream front end that serialises a bitstream into the
//            FPGA configuration chain, with readback verify and clear.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_cfg_ctrl
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 96,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [DATA_W-1:0]    din_data,
    output logic                 prog_en,
    output logic                 prog_in,
    input  logic                 prog_out,
    output logic                 fabric_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                 c_REM_W = $clog2(CHAIN_LEN + 1);
    localparam int                 c_BC_W  = $clog2(DATA_W + 1);
    localparam logic [c_REM_W-1:0] c_CHAIN = c_REM_W'(CHAIN_LEN);

    cfg_state_e            r_state;
    cfg_state_e            w_state_nxt;
    cfg_op_e               r_op;
    logic [c_REM_W-1:0]    r_remaining;
    logic                  r_error;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_ser_load;
    logic [DATA_W-1:0]     w_ser_data;
    logic [c_BC_W-1:0]     w_ser_bits;
    logic                  w_ser_shift;
    logic                  w_ser_bit;
    logic                  w_ser_empty;
    logic [c_BC_W-1:0]     w_fetch_bits;
    logic                  w_shifting;

    // The last word may be partial: only the bits still owed to the chain are counted.
    assign w_fetch_bits = (32'(r_remaining) >= DATA_W) ? c_BC_W'(DATA_W)
                                                        : c_BC_W'(r_remaining);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ser_load  = 1'b0;
        w_ser_data  = '0;
        w_ser_bits  = '0;
        w_ser_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cfg_op_e'(cmd_op))
                        LOAD, VERIFY: w_state_nxt = FETCH;
                        CLEAR: begin
                            w_state_nxt = SHIFT;
                            w_ser_load  = 1'b1;
                        end
                        default: w_state_nxt = DONE;
                    endcase
                end
            end
            FETCH: begin
                if (din_valid) begin
                    w_state_nxt = SHIFT;
                    w_ser_load  = 1'b1;
                    w_ser_data  = din_data;
                    w_ser_bits  = w_fetch_bits;
                end
            end
            SHIFT: begin
                w_ser_shift = 1'b1;
                if (r_remaining == c_REM_W'(1)) begin
                    w_state_nxt = DONE;
                end else if (r_op != CLEAR && w_ser_empty) begin
                    w_state_nxt = FETCH;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= LOAD;
            r_remaining <= '0;
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
        end else if (r_state == IDLE && cmd_valid) begin
            r_op        <= cfg_op_e'(cmd_op);
            r_remaining <= c_CHAIN;
            r_error     <= (cfg_op_e'(cmd_op) == ILLEGAL);
            r_err_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_remaining <= r_remaining - c_REM_W'(1);
            // The bit leaving the chain end now is the one written in this position last time.
            if (r_op == VERIFY && prog_out != w_ser_bit) begin
                r_error <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    cfg_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_ser_load),
        .load_data (w_ser_data),
        .load_bits (w_ser_bits),
        .shift     (w_ser_shift),
        .ser_bit   (w_ser_bit),
        .empty     (w_ser_empty)
    );

    assign w_shifting = (r_state == SHIFT);
    assign cmd_ready  = (r_state == IDLE);
    assign din_ready  = (r_state == FETCH);
    assign prog_en    = w_shifting;
    assign prog_in    = w_shifting & w_ser_bit;
    assign busy       = (r_state != IDLE);
    assign fabric_rst = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign error      = r_error;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpga_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_cfg_ctrl
// Brief    : Directed self-checking bench for fpga_cfg_ctrl on a 20-bit chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_cfg_ctrl;

    localparam int CHAIN_LEN = 20;
    localparam int DATA_W    = 8;
    localparam int ERR_CNT_W = 3;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_VERIFY = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_BAD    = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = 2'd0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic [DATA_W-1:0]    din_data = '0;
    logic                 prog_en;
    logic                 prog_in;
    logic                 prog_out;
    logic                 fabric_rst;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [ERR_CNT_W-1:0] err_cnt;

    fpga_cfg_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .prog_en    (prog_en),
        .prog_in    (prog_in),
        .prog_out   (prog_out),
        .fabric_rst (fabric_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural configuration chain
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge clk) begin
        if (prog_en) chain <= {chain[CHAIN_LEN-2:0], prog_in};
    end
    assign prog_out = chain[CHAIN_LEN-1];

    int   cyc = 0;
    int   en_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic bits_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prog_en) begin
            bits_q.push_back(prog_in);
            en_cnt <= en_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, output int t0);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        t0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        din_valid = 1'b1;
        din_data  = d;
        wait_fetch();
        check_eq("din_ready", 32'(din_ready), 1);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done), 1);
        @(negedge clk);
    endtask

    task automatic run_words(input logic [1:0] op, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input bit stall, output int t0);
        issue_cmd(op, t0);
        send_word(w0);
        if (stall) begin
            wait_fetch();
            for (int i = 0; i < 3; i++) begin
                check_eq("stall_prog_en", 32'(prog_en), 0);
                check_eq("stall_fabric_rst", 32'(fabric_rst), 1);
                @(negedge clk);
            end
        end
        send_word(w1);
        send_word(w2);
        wait_done();
    endtask

    function automatic logic [CHAIN_LEN-1:0] get_stream(input int q0);
        logic [CHAIN_LEN-1:0] s = '0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (q0 + i < bits_q.size()) s[i] = bits_q[q0 + i];
        end
        return s;
    endfunction

    int t0, en0, d0, q0;

    task automatic snap();
        en0 = en_cnt;
        d0  = done_cnt;
        q0  = bits_q.size();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        check_eq("rst_prog_en", 32'(prog_en), 0);
        check_eq("rst_prog_in", 32'(prog_in), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_fabric_rst", 32'(fabric_rst), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
        check_eq("rst_din_ready", 32'(din_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset on the 5th shift cycle of a LOAD
        issue_cmd(OP_LOAD, t0);
        send_word(8'hA5);
        check_eq("t1_shifting", 32'(prog_en), 1);
        repeat (4) @(negedge clk);
        check_eq("t1_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_eq("t1_prog_en", 32'(prog_en), 0);
        check_eq("t1_busy", 32'(busy), 0);
        check_eq("t1_fabric_rst", 32'(fabric_rst), 0);
        check_eq("t1_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LOAD with a partial last word
        snap();
        run_words(OP_LOAD, 8'hA5, 8'h3C, 8'hFF, 1'b0, t0);
        check_eq("t2_en_cycles", 32'(en_cnt - en0), 20);
        check_eq("t2_stream", 32'(get_stream(q0)), 32'h000F3CA5);
        check_eq("t2_done_pulses", 32'(done_cnt - d0), 1);
        check_eq("t2_latency", 32'(done_cyc - t0), 24);
        check_eq("t2_error", 32'(error), 0);
        check_eq("t2_busy", 32'(busy), 0);

        // VERIFY with matching stream
        snap();
        run_words(OP_VERIFY, 8'hA5, 8'h3C, 8'hFF, 1'b0, t0);
        check_eq("t3_en_cycles", 32'(en_cnt - en0), 20);
        check_eq("t3_error", 32'(error), 0);
        check_eq("t3_err_cnt", 32'(err_cnt), 0);
        check_eq("t3_done_pulses", 32'(done_cnt - d0), 1);

        // VERIFY with one flipped bit
        snap();
        run_words(OP_VERIFY, 8'hA4, 8'h3C, 8'hFF, 1'b0, t0);
        check_eq("t4_error", 32'(error), 1);
        check_eq("t4_err_cnt", 32'(err_cnt), 1);
        check_eq("t4_stream", 32'(get_stream(q0)), 32'h000F3CA4);

        // LOAD with a 3-cycle stall before the second word
        snap();
        run_words(OP_LOAD, 8'hA5, 8'h3C, 8'hFF, 1'b1, t0);
        check_eq("t5_en_cycles", 32'(en_cnt - en0), 20);
        check_eq("t5_stream", 32'(get_stream(q0)), 32'h000F3CA5);
        check_eq("t5_latency", 32'(done_cyc - t0), 27);
        check_eq("t5_error_cleared", 32'(error), 0);
        check_eq("t5_chain", 32'(chain), 32'h000A53CF);

        // CLEAR
        snap();
        issue_cmd(OP_CLEAR, t0);
        wait_done();
        check_eq("t6_en_cycles", 32'(en_cnt - en0), 20);
        check_eq("t6_stream", 32'(get_stream(q0)), 0);
        check_eq("t6_latency", 32'(done_cyc - t0), 21);
        check_eq("t6_done_pulses", 32'(done_cnt - d0), 1);
        check_eq("t6_chain", 32'(chain), 0);

        // VERIFY all-ones against a cleared chain: counter saturates
        snap();
        run_words(OP_VERIFY, 8'hFF, 8'hFF, 8'hFF, 1'b0, t0);
        check_eq("t7_error", 32'(error), 1);
        check_eq("t7_err_cnt_sat", 32'(err_cnt), 7);

        // Illegal op
        snap();
        issue_cmd(OP_BAD, t0);
        wait_done();
        check_eq("t8_en_cycles", 32'(en_cnt - en0), 0);
        check_eq("t8_latency", 32'(done_cyc - t0), 1);
        check_eq("t8_error", 32'(error), 1);
        check_eq("t8_err_cnt", 32'(err_cnt), 0);
        check_eq("t8_done_pulses", 32'(done_cnt - d0), 1);
        check_eq("t8_cmd_ready", 32'(cmd_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
